// File: rtl/bin_down_timer_rtl_pkg.sv
// Shared definitions for the loadable down-counter/timer: controller state
// encoding and default count width.
package bin_down_timer_rtl_pkg;

  localparam int DEFAULT_SIZE = 4;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] RUN   = 2'b10;

endpackage : bin_down_timer_rtl_pkg

// File: rtl/bin_down_timer_rtl_down_count_datapath.sv
// Datapath for the down timer: count and reload registers plus zero/one
// detect. It only acts on strobes from the controller; it makes no decisions.
module down_count_datapath
  import bin_down_timer_rtl_pkg::*;
#(
  parameter int size = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,       // count and reload register take load_val
  input  logic [size-1:0] load_val,
  input  logic            dec,        // count decrements by one
  input  logic            reload,     // count takes the reload register
  output logic [size-1:0] count,
  output logic            is_zero,
  output logic            is_one,
  output logic            reload_zero
);

  logic [size-1:0] reload_reg;

  // Modulo-2^size decrement; the controller never asks for it at zero.
  function automatic logic [size-1:0] dec_one(input logic [size-1:0] v);
    return v - {{(size-1){1'b0}}, 1'b1};
  endfunction

  // Count register: load beats reload beats decrement (strobes are exclusive
  // in practice, the ordering just makes the intent explicit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      count <= load_val;
    end else if (reload) begin
      count <= reload_reg;
    end else if (dec) begin
      count <= dec_one(count);
    end
  end

  // Reload register: only rewritten by an explicit load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_reg <= '0;
    end else if (load) begin
      reload_reg <= load_val;
    end
  end

  assign is_zero     = (count == '0);
  assign is_one      = (count == {{(size-1){1'b0}}, 1'b1});
  assign reload_zero = (reload_reg == '0);

endmodule : down_count_datapath

// File: rtl/bin_down_timer_rtl.sv
// Loadable binary down-counter/timer. The controller FSM lives here and
// steers down_count_datapath through load/dec/reload strobes; done is a
// registered one-cycle pulse when the count reaches zero.
module bin_down_timer_rtl
  import bin_down_timer_rtl_pkg::*;
#(
  parameter int size = DEFAULT_SIZE
) (
  input  logic            clk_21,
  input  logic            rst_21,
  input  logic            load_21,
  input  logic [size-1:0] load_val_21,
  input  logic            start_21,
  input  logic            stop_21,
  input  logic            enb_21,
  input  logic            reload_21,
  output logic [size-1:0] count_21,
  output logic            busy_21,
  output logic            done_21
);

  logic [1:0] state, next_state;
  logic       dp_load, dp_dec, dp_reload, done_next;
  logic       is_zero, is_one, reload_zero;

  down_count_datapath #(.size(size)) u_datapath (
    .clk         (clk_21),
    .rst_n       (rst_21),
    .load        (dp_load),
    .load_val    (load_val_21),
    .dec         (dp_dec),
    .reload      (dp_reload),
    .count       (count_21),
    .is_zero     (is_zero),
    .is_one      (is_one),
    .reload_zero (reload_zero)
  );

  // Next-state and strobe decode for the IDLE/ARMED/RUN controller.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    next_state = state;
    dp_load    = 1'b0;
    dp_dec     = 1'b0;
    dp_reload  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load_21) begin
          dp_load    = 1'b1;
          next_state = ARMED;
        end
      end
      ARMED: begin
        if (load_21) begin
          dp_load = 1'b1;
        end else if (start_21) begin
          if (is_zero) begin
            done_next  = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (stop_21) begin
          next_state = IDLE;
        end else if (is_zero) begin
          // Only reachable for the one cycle after done in auto-reload mode.
          dp_reload = 1'b1;
        end else if (enb_21) begin
          dp_dec = 1'b1;
          if (is_one) begin
            done_next = 1'b1;
            // A zero reload value would just re-terminate, so go idle instead.
            if (!(reload_21 && !reload_zero)) next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk_21 or negedge rst_21) begin
    if (!rst_21) begin
      state   <= IDLE;
      busy_21 <= 1'b0;
      done_21 <= 1'b0;
    end else begin
      state   <= next_state;
      busy_21 <= (next_state == RUN);
      done_21 <= done_next;
    end
  end

endmodule : bin_down_timer_rtl

// File: tb/tb_bin_down_timer_rtl.sv
// Directed bench for bin_down_timer_rtl with hand-computed expectations.
module tb_bin_down_timer_rtl;

  logic       clk_21 = 1'b0;
  logic       rst_21;
  logic       load_21, start_21, stop_21, enb_21, reload_21;
  logic [3:0] load_val_21;
  logic [3:0] count_21;
  logic       busy_21, done_21;

  int tests_run = 0;
  int tests_failed = 0;

  bin_down_timer_rtl #(.size(4)) dut (
    .clk_21      (clk_21),
    .rst_21      (rst_21),
    .load_21     (load_21),
    .load_val_21 (load_val_21),
    .start_21    (start_21),
    .stop_21     (stop_21),
    .enb_21      (enb_21),
    .reload_21   (reload_21),
    .count_21    (count_21),
    .busy_21     (busy_21),
    .done_21     (done_21)
  );

  always #5 clk_21 = ~clk_21;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c,
                           input logic b, input logic d);
    check({tag, ".count"}, 32'(count_21), 32'(c));
    check({tag, ".busy"},  32'(busy_21),  32'(b));
    check({tag, ".done"},  32'(done_21),  32'(d));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_21);
    #1;
  endtask

  initial begin
    rst_21 = 1'b0; load_21 = 0; start_21 = 0; stop_21 = 0;
    enb_21 = 0; reload_21 = 0; load_val_21 = '0;
    tick(); tick();
    check_all("reset", 4'd0, 1'b0, 1'b0);
    rst_21 = 1'b1;
    tick();

    // Reset mid-run: load 9, start, three enabled decrements, then reset.
    load_21 = 1; load_val_21 = 4'd9; tick(); load_21 = 0;
    check_all("mid.armed", 4'd9, 1'b0, 1'b0);
    start_21 = 1; tick(); start_21 = 0;
    check_all("mid.run", 4'd9, 1'b1, 1'b0);
    enb_21 = 1; tick(); tick(); tick();
    check_all("mid.dec3", 4'd6, 1'b1, 1'b0);
    rst_21 = 1'b0; #1;
    check_all("mid.async", 4'd0, 1'b0, 1'b0);
    tick(); rst_21 = 1'b1; tick();
    start_21 = 1; tick(); start_21 = 0;
    check_all("mid.idle_start", 4'd0, 1'b0, 1'b0);

    // Basic timing: load 5, start, enable held high.
    enb_21 = 1;
    load_21 = 1; load_val_21 = 4'd5; tick(); load_21 = 0;
    start_21 = 1; tick(); start_21 = 0;
    check_all("basic.entry", 4'd5, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      check_all($sformatf("basic.c%0d", i), 4'(i), 1'b1, 1'b0);
    end
    tick();
    check_all("basic.done", 4'd0, 1'b0, 1'b1);
    tick();
    check_all("basic.after", 4'd0, 1'b0, 1'b0);

    // Gated enable: 1,0,1,0,1 -> 2,2,1,1,0.
    enb_21 = 0;
    load_21 = 1; load_val_21 = 4'd3; tick(); load_21 = 0;
    start_21 = 1; tick(); start_21 = 0;
    check_all("gate.entry", 4'd3, 1'b1, 1'b0);
    begin
      logic [4:0] enb_pat;
      logic [3:0] exp_cnt [5];
      enb_pat = 5'b10101;
      exp_cnt = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
      for (int i = 0; i < 5; i++) begin
        enb_21 = enb_pat[4-i];
        tick();
        check_all($sformatf("gate.s%0d", i), exp_cnt[i], (i != 4), (i == 4));
      end
    end
    enb_21 = 0; tick();
    check_all("gate.after", 4'd0, 1'b0, 1'b0);

    // Auto-reload: load 15, done every 16 enabled cycles, busy stays high.
    reload_21 = 1; enb_21 = 1;
    load_21 = 1; load_val_21 = 4'd15; tick(); load_21 = 0;
    start_21 = 1; tick(); start_21 = 0;
    check_all("rel.entry", 4'd15, 1'b1, 1'b0);
    for (int i = 14; i >= 1; i--) tick();
    check_all("rel.c1", 4'd1, 1'b1, 1'b0);
    tick();
    check_all("rel.done1", 4'd0, 1'b1, 1'b1);
    tick();
    check_all("rel.reloaded", 4'd15, 1'b1, 1'b0);
    for (int i = 14; i >= 1; i--) tick();
    tick();
    check_all("rel.done2", 4'd0, 1'b1, 1'b1);
    stop_21 = 1; tick(); stop_21 = 0;
    check_all("rel.stop_zero", 4'd0, 1'b0, 1'b0);
    reload_21 = 0;

    // Stop after two decrements: count holds at 4, no done.
    load_21 = 1; load_val_21 = 4'd6; tick(); load_21 = 0;
    start_21 = 1; tick(); start_21 = 0;
    tick(); tick();
    check_all("stop.dec2", 4'd4, 1'b1, 1'b0);
    stop_21 = 1; tick(); stop_21 = 0;
    check_all("stop.idle", 4'd4, 1'b0, 1'b0);
    tick();
    check_all("stop.hold", 4'd4, 1'b0, 1'b0);

    // Start with zero: single done pulse, then IDLE.
    load_21 = 1; load_val_21 = 4'd0; tick(); load_21 = 0;
    check_all("zero.armed", 4'd0, 1'b0, 1'b0);
    start_21 = 1; tick(); start_21 = 0;
    check_all("zero.done", 4'd0, 1'b0, 1'b1);
    tick();
    check_all("zero.after", 4'd0, 1'b0, 1'b0);
    start_21 = 1; tick(); start_21 = 0;
    check_all("zero.idle_start", 4'd0, 1'b0, 1'b0);

    // Priority: load beats start in ARMED; load ignored in RUN.
    enb_21 = 0;
    load_21 = 1; load_val_21 = 4'd2; tick();
    load_val_21 = 4'd7; start_21 = 1; tick(); load_21 = 0; start_21 = 0;
    check_all("prio.load_start", 4'd7, 1'b0, 1'b0);
    tick();
    check_all("prio.armed", 4'd7, 1'b0, 1'b0);
    start_21 = 1; tick(); start_21 = 0;
    check_all("prio.run", 4'd7, 1'b1, 1'b0);
    load_21 = 1; load_val_21 = 4'd3; tick(); load_21 = 0;
    check_all("prio.run_load", 4'd7, 1'b1, 1'b0);
    enb_21 = 1; tick();
    check_all("prio.dec", 4'd6, 1'b1, 1'b0);
    stop_21 = 1; tick(); stop_21 = 0;
    check_all("prio.stop", 4'd6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_bin_down_timer_rtl

// File: doc/bin_down_timer_rtl.md
Name: bin_down_timer_rtl

Overview:
Loadable binary down-counter/timer. It is the consuming counterpart of the free-running up counter: software or upstream logic loads a terminal count, starts the timer, and receives a one-cycle done pulse when the count reaches zero. The block has a controller FSM and a datapath sub-module, with the same controller/datapath split used elsewhere in the codebase. It gates its decrement with an enable input so that the existing divide-by-N enable generators can pace it.

Parameters:
size, 4, width of the count, load value and reload register

Ports:
clk_21  input  1  single clock; all state changes on its rising edge
rst_21  input  1  asynchronous, active-low reset (0 = reset asserted)
load_21  input  1  load load_val_21 into count and reload register
load_val_21  input  size  value to load
start_21  input  1  begin counting from the loaded value
stop_21  input  1  abort the current run; count holds its value
enb_21  input  1  decrement qualifier (pacing enable)
reload_21  input  1  auto-reload mode: restart from the reload register after done
count_21  output  size  current count (registered)
busy_21  output  1  high while in RUN
done_21  output  1  one-cycle pulse when count reaches 0

Behaviour:
- Reset (rst_21 low, asynchronous): state IDLE; count_21=0, reload register=0, busy_21=0, done_21=0. Release is synchronous to the next clock.
- States: IDLE, ARMED, RUN. busy_21 is 1 only in RUN. All outputs are registered.
- IDLE:
  - load_21=1: count and reload register take load_val_21; go to ARMED.
  - start_21 is ignored in IDLE.
- ARMED:
  - load_21=1: reload the count and reload register; stay ARMED. Load has priority over start in the same cycle.
  - start_21=1 and count!=0: go to RUN.
  - start_21=1 and count==0: done_21 pulses on the next edge; go to IDLE.
- RUN:
  - enb_21=1 and count>1: count decrements by 1.
  - enb_21=1 and count==1: count becomes 0 and done_21=1 for exactly one cycle on the same edge.
    - reload_21=1: count takes the reload register value; stay in RUN. count_21 reads 0 for that one cycle, then the reload value. The reload value is captured on the edge after done.
    - reload_21=0: go to IDLE; count stays 0.
  - enb_21=0: count holds.
  - stop_21=1: go to IDLE, count holds, no done pulse. stop_21 has priority over a decrement in the same cycle.
  - load_21 and start_21 are ignored in RUN.
- Latency: load N, then start with enb_21 held high. RUN is entered at edge k; done_21 is high after edge k+N. Exactly N decrements occur.
- Count never wraps below 0. The maximum load is 2^size-1, all arithmetic is modulo 2^size, and no carry-out is produced.
- Reload register value 0 with reload_21=1: after done, go to IDLE (the same rule as start with count 0, without a further pulse).
- done_21 never pulses in IDLE or ARMED except for the start-with-zero case.
- Reset asserted mid-run: immediate return to the reset values. No done pulse.

Decomposition:
- Shared package:
  - state encoding localparams: IDLE=2'b00, ARMED=2'b01, RUN=2'b10
  - default size
- One sub-module, down_count_datapath:
  - holds the count and reload registers
  - decrement function and zero/one detect
  - controlled by load/dec/reload strobes from the FSM in the top level
- The controller FSM stays in bin_down_timer_rtl.

Test Plan:
- Reset mid-run: load 9, start, pull rst_21 low after 3 enabled cycles -> count_21=0, busy_21=0, done_21=0 immediately; IDLE after release.
- Basic timing: load 5, start, enb_21=1 continuously -> count_21 goes 5,4,3,2,1,0; done_21 high for one cycle, 5 edges after RUN entry; busy_21 drops on the same edge.
- Gated enable: load 3, enb_21 toggling 1,0,1,0,1 -> count goes 3,2,2,1,1,0; done_21 pulses once.
- Auto-reload: size=4, load 15, reload_21=1 -> done_21 pulses every 16 enabled cycles; count_21 goes 0 then 15; busy_21 stays 1.
- Stop and start-with-zero:
  - load 6, start, stop after 2 decrements -> count_21=4, no done_21, IDLE.
  - load 0, start -> single done_21 pulse, then IDLE.
- Priority: load 7 and start together in ARMED -> count_21=7 and state stays ARMED; load_21 asserted during RUN leaves the count unchanged.
